// File: rtl/arbiter_pkg.sv
// Shared helpers for the round-robin arbiter: pointer width and wrapping increment.
package arbiter_pkg;

  // Pointer width; a 1-bit floor keeps degenerate sizes legal.
  function automatic int ptr_width(input int size);
    int w;
    w = $clog2(size);
    return (w < 1) ? 1 : w;
  endfunction

  // Advance a pointer by one with an explicit wrap at size-1, so non-power-of-2 sizes stay in range.
  function automatic int ptr_increment(input int p, input int size);
    return (p == size - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/balanced_round_robin_arbiter_lsb_priority_encoder_onehot.sv
// One-hot encoder of the lowest set bit of a vector; all-zero in gives all-zero out.
module lsb_priority_encoder_onehot #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // Two's-complement trick isolates the least significant set bit.
  assign out = in & (~in + {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/balanced_round_robin_arbiter.sv
// Round-robin arbiter with a combinational one-hot grant and a registered priority pointer.
// Optional simulation checks: define BALANCED_ROUND_ROBIN_ARBITER_ASSERTIONS_EN.
module balanced_round_robin_arbiter
  import arbiter_pkg::*;
#(
  parameter int SIZE            = 4,
  parameter int ROTATE_ON_GRANT = 0
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [SIZE-1:0] requests,
  output logic [SIZE-1:0] grant
);

  localparam int PW = ptr_width(SIZE);

  logic [PW-1:0]   ptr, ptr_nxt, gidx;
  logic [SIZE-1:0] mask, masked, gnt_masked, gnt_raw;

  // High-side mask: requesters at or above the pointer get first pick.
  always_comb begin
    mask = '0;
    for (int i = 0; i < SIZE; i++) mask[i] = (i >= int'(ptr));
  end

  assign masked = requests & mask;

  lsb_priority_encoder_onehot #(.WIDTH(SIZE)) u_enc_masked (.in(masked),   .out(gnt_masked));
  lsb_priority_encoder_onehot #(.WIDTH(SIZE)) u_enc_raw    (.in(requests), .out(gnt_raw));

  // Fall back to the unmasked search when nobody sits at or above the pointer (wrap-around).
  assign grant = (|masked) ? gnt_masked : gnt_raw;

  // Binary index of the granted requester, used for grant-following rotation.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < SIZE; i++) if (grant[i]) gidx = PW'(i);
  end

  // Next pointer: free-running rotation, or one past the winner when a grant happens.
  always_comb begin
    ptr_nxt = ptr;
    if (ROTATE_ON_GRANT == 0) ptr_nxt = PW'(ptr_increment(int'(ptr), SIZE));
    else if (|grant)          ptr_nxt = PW'(ptr_increment(int'(gidx), SIZE));
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) ptr <= '0;
    else         ptr <= ptr_nxt;
  end

`ifdef BALANCED_ROUND_ROBIN_ARBITER_ASSERTIONS_EN
  // Grant invariants checked on every active edge outside reset.
  always_ff @(posedge clock) begin
    if (resetn) begin
      assert ($countones(grant) <= 1)
        else $error("%0t arbiter: grant not at most one-hot grant=%b requests=%b", $time, grant, requests);
      assert ((grant & ~requests) == '0)
        else $error("%0t arbiter: grant without request grant=%b requests=%b", $time, grant, requests);
      assert (!(|requests) || ($countones(grant) == 1))
        else $error("%0t arbiter: request left ungranted grant=%b requests=%b", $time, grant, requests);
      assert (int'(ptr) < SIZE)
        else $error("%0t arbiter: pointer out of range ptr=%0d grant=%b requests=%b", $time, ptr, grant, requests);
    end
  end
`else
  // No checking logic in the default build.
`endif

endmodule

// File: tb/tb_balanced_round_robin_arbiter.sv
// Bench: free-running (SIZE=4), grant-following (SIZE=4) and free-running SIZE=3 arbiters
// driven with the same requests and checked against a circular-scan reference model.
module tb_balanced_round_robin_arbiter;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] requests = '0;
  logic [3:0] grant0, grant1;
  logic [2:0] req3, grant3;

  int checks = 0;
  int failures = 0;

  int p0 = 0, p1 = 0, p3 = 0;
  logic [3:0] last0, last1, last3;
  logic [3:0] exp_q0[$], exp_q1[$], exp_q3[$];

  int req_cnt[4], g0_cnt[4], g1_cnt[4];

  assign req3 = requests[2:0];

  always #5 clock = ~clock;

  balanced_round_robin_arbiter #(.SIZE(4), .ROTATE_ON_GRANT(0)) u0 (
    .clock(clock), .resetn(resetn), .requests(requests), .grant(grant0));
  balanced_round_robin_arbiter #(.SIZE(4), .ROTATE_ON_GRANT(1)) u1 (
    .clock(clock), .resetn(resetn), .requests(requests), .grant(grant1));
  balanced_round_robin_arbiter #(.SIZE(3), .ROTATE_ON_GRANT(0)) u3 (
    .clock(clock), .resetn(resetn), .requests(req3), .grant(grant3));

  // Reference: scan circularly from the pointer, first requester wins.
  function automatic logic [3:0] ref_grant(input logic [3:0] r, input int p, input int n);
    logic [3:0] one;
    one = 4'd1;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (p + k) % n;
      if (r[idx]) return one << idx;
    end
    return 4'd0;
  endfunction

  function automatic int onehot_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s got=%b expected=%b", tag, act, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic act);
    checks++;
    assert (act === 1'b1) else begin
      failures++;
      $error("FAIL %s got=%b expected=1", tag, act);
    end
  endtask

  // One cycle: drive at negedge, push expectations, sample mid-cycle, advance model at posedge.
  task automatic step(input logic rn, input logic [3:0] r);
    logic [3:0] e1;
    @(negedge clock);
    resetn   = rn;
    requests = r;
    exp_q0.push_back(ref_grant(r, p0, 4));
    e1 = ref_grant(r, p1, 4);
    exp_q1.push_back(e1);
    exp_q3.push_back(ref_grant({1'b0, r[2:0]}, p3, 3));
    #2;
    last0 = grant0;
    last1 = grant1;
    last3 = {1'b0, grant3};
    chk("sb_rot_clk", last0, exp_q0.pop_front());
    chk("sb_rot_gnt", last1, exp_q1.pop_front());
    chk("sb_size3",   last3, exp_q3.pop_front());
    chk_bit("onehot_u1", ($countones(last1) <= 1) && ((last1 & ~r) == 4'd0));
    @(posedge clock);
    if (!rn) begin
      p0 = 0; p1 = 0; p3 = 0;
    end else begin
      p0 = (p0 + 1) % 4;
      p3 = (p3 + 1) % 3;
      if (e1 != 4'd0) p1 = (onehot_idx(e1) + 1) % 4;
    end
  endtask

  initial begin
    logic [3:0] bits, orv;

    // Reset state: nothing requested, nothing granted, even while held in reset.
    step(1'b0, 4'b0000);
    chk("reset_g0", last0, 4'b0000);
    chk("reset_g1", last1, 4'b0000);
    step(1'b0, 4'b0100);
    chk("in_reset_comb", last0, 4'b0100);

    // Single requester wins at every pointer position.
    for (int b = 0; b < 4; b++) begin
      bits = 4'd1 << b;
      for (int c = 0; c < 4; c++) begin
        step(1'b1, bits);
        chk("single_g0", last0, bits);
        chk("single_g1", last1, bits);
      end
    end

    // Idle: no grants.
    step(1'b1, 4'b0000);
    chk("idle_g0", last0, 4'b0000);
    chk("idle_g1", last1, 4'b0000);
    step(1'b1, 4'b0000);
    chk("idle_g0b", last0, 4'b0000);

    // Full load after reset: strict rotation in both modes.
    step(1'b0, 4'b0000);
    orv = '0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 4'b1111);
      chk("full_g0", last0, 4'd1 << c);
      chk("full_g1", last1, 4'd1 << c);
      orv |= last0;
    end
    chk("full_or", orv, 4'b1111);

    // Two sparse requesters alternate under grant-following rotation.
    step(1'b0, 4'b0000);
    step(1'b1, 4'b1010); chk("alt1_g1", last1, 4'b0010);
    step(1'b1, 4'b1010); chk("alt2_g1", last1, 4'b1000);
    step(1'b1, 4'b1010); chk("alt3_g1", last1, 4'b0010);

    // Wrap: both pointers at 3, low requesters only.
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0100); chk("pre_wrap_g1", last1, 4'b0100);
    step(1'b1, 4'b0011); chk("wrap_g0", last0, 4'b0001); chk("wrap_g1", last1, 4'b0001);
    step(1'b1, 4'b0011); chk("post_wrap_g0", last0, 4'b0001); chk("post_wrap_g1", last1, 4'b0010);

    // Reset mid-operation returns the pointer to 0.
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1111);
    step(1'b0, 4'b1111);
    step(1'b1, 4'b1111);
    chk("midrst_g0", last0, 4'b0001);
    chk("midrst_g1", last1, 4'b0001);

    // Random traffic with fairness accounting.
    for (int c = 0; c < 1000; c++) begin
      bits = 4'($urandom_range(0, 15));
      step(1'b1, bits);
      chk_bit("onehot_u0", ($countones(last0) <= 1) && ((last0 & ~bits) == 4'd0) &&
                           ((bits == 4'd0) || ($countones(last0) == 1)));
      for (int i = 0; i < 4; i++) begin
        req_cnt[i] += int'(bits[i]);
        g0_cnt[i]  += int'(last0[i]);
        g1_cnt[i]  += int'(last1[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk_bit("fair_g0", (req_cnt[i] > 0) && (4 * g0_cnt[i] >= req_cnt[i]) && (4 * g0_cnt[i] <= 3 * req_cnt[i]));
      chk_bit("fair_g1", (req_cnt[i] > 0) && (4 * g1_cnt[i] >= req_cnt[i]) && (4 * g1_cnt[i] <= 3 * req_cnt[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/balanced_round_robin_arbiter.md
Name: balanced_round_robin_arbiter

Overview:
- Single-cycle, combinational-grant round-robin arbiter over SIZE request lines.
- Grant is one-hot, derived from the live requests and a registered priority pointer that rotates to give every requester equal long-run service.
- Sits in front of any shared resource (bus, port, buffer) needing fair one-per-cycle access.

Parameters:
- SIZE, 4, number of requesters (>=2); width of requests/grant.
- ROTATE_ON_GRANT, 0, 0 = pointer advances by one every clock; 1 = pointer moves to one past the granted index, only on cycles with a grant.

Ports:
- clock  input  1  clock; all state updates on rising edge.
- resetn  input  1  reset, synchronous, active-low.
- requests  input  SIZE  request vector; bit i = requester i wants access this cycle.
- grant  output  SIZE  one-hot grant; bit i = requester i owns the resource this cycle.

Behaviour:
- State is only the priority pointer, ptr, of width clog2(SIZE), range 0..SIZE-1.
- Reset: on a rising edge with resetn=0, ptr <= 0.
- Grant is purely combinational, with zero latency, from requests and the current ptr; there are no registered outputs.
- Grant selection:
  - Form a high-side mask of bits with index >= ptr.
  - masked = requests & mask.
  - If masked != 0, grant = lowest set bit of masked.
  - Otherwise, grant = lowest set bit of requests (wrap-around).
- grant is 0 if and only if requests is 0. Otherwise grant has exactly one bit set, and that bit is set in requests.
- Pointer update, ROTATE_ON_GRANT=0: every rising edge with resetn=1, ptr <= (ptr==SIZE-1) ? 0 : ptr+1, regardless of requests.
- Pointer update, ROTATE_ON_GRANT=1:
  - On an edge with grant != 0: ptr <= (g==SIZE-1) ? 0 : g+1, where g is the granted index.
  - When there is no grant, ptr holds.
- Wrap-around: ptr never leaves 0..SIZE-1. For non-power-of-2 SIZE, the increment must wrap explicitly at SIZE-1.
- Single active request: that request is granted at every ptr value.
- All requests active for SIZE consecutive cycles: every requester is granted exactly once, in both modes.
- Requests are sampled only combinationally; no request hold or handshake is required. A dropped request loses its grant in the same cycle.
- Reset mid-operation: the next edge returns ptr to 0. grant stays combinational while in reset (no gating).

Optional Feature:
- Macro BALANCED_ROUND_ROBIN_ARBITER_ASSERTIONS_EN.
- When defined, the RTL includes simulation assertions checked on each rising edge with resetn=1:
  - $countones(grant) <= 1.
  - (grant & ~requests) == 0.
  - (|requests) implies $countones(grant) == 1.
  - ptr < SIZE.
- Each failure emits $error with the time and both vectors.
- When undefined, no assertion code is compiled; functional behaviour is identical.

Decomposition:
- Shared package arbiter_pkg holds:
  - function clog2-safe pointer width: max(1, $clog2(SIZE)).
  - function ptr_increment with wrap at SIZE.
- One sub-module is natural: lsb_priority_encoder_onehot, parameter WIDTH; input vector in, output one-hot lowest set bit.
  - Instantiated twice: on the masked requests and on the raw requests.

Test Plan:
- Reset, then requests=4'b0100 held for 4 cycles (all ptr positions) -> grant=4'b0100 every cycle; repeat for each single bit 0001/0010/1000.
- requests=4'b0000 -> grant=4'b0000 on every cycle.
- ROTATE_ON_GRANT=0, after reset requests=4'b1111 for 4 cycles -> grants 0001, 0010, 0100, 1000; OR of grants = 4'b1111.
- ROTATE_ON_GRANT=1, ptr=0, requests=4'b1010 -> grant 0010, then 1000, then 0010 (alternating); with 4'b1111 -> strict rotation 0001, 0010, 0100, 1000.
- Wrap: ptr=3, requests=4'b0011 -> grant=4'b0001; with ROTATE_ON_GRANT=1 the next ptr is 1.
- 1000 cycles of random requests (changed at negedge) -> per-channel grants/requests ratio in [1/SIZE, 1-1/SIZE]; one-hot and grant-implies-request hold on every cycle.
